// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: RX FIFO read-side bundle between the UART receiver and the APB register block.
//   rx_pop        pop the head entry (ignored when empty)
//   rx_data       head data, first-word-fall-through, 0 when empty
//   rx_status     head status {bi, fe, pe}, 0 when empty
//   rx_fifo_empty / rx_fifo_full / rx_fifo_count  FIFO flags and occupancy
//   overrun       one-cycle pulse when a character arrives while full
interface uart_rx_core_if;
    logic       rx_pop;
    logic [7:0] rx_data;
    logic [2:0] rx_status;
    logic       rx_fifo_empty;
    logic       rx_fifo_full;
    logic [4:0] rx_fifo_count;
    logic       overrun;
    modport master (output rx_pop, input rx_data, rx_status, rx_fifo_empty, rx_fifo_full, rx_fifo_count, overrun);
    modport slave (input rx_pop, output rx_data, rx_status, rx_fifo_empty, rx_fifo_full, rx_fifo_count, overrun);
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receiver, deserialises RXD with 16x oversampling into a tagged RX FIFO.
//   clock    system clock
//   PRESETn  asynchronous active-low reset
//   baud_o   one-clock enable pulse at 16x the bit rate
//   RXD      serial input, idle high, asynchronous to clock
//   lcr      {stick, even, parity_en, stop_bits, word_len[1:0]}
//   rx_busy  frame in progress
//   rx       FIFO read side (uart_rx_core_if.slave)
module uart_rx_core #(
    parameter int FIFO_DEPTH = 16,
    parameter int OVERSAMPLE = 16,
    parameter int SAMPLE_PT  = 7
) (
    input  logic             clock,
    input  logic             PRESETn,
    input  logic             baud_o,
    input  logic             RXD,
    input  logic [5:0]       lcr,
    output logic             rx_busy,
    uart_rx_core_if.slave    rx
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state, state_nxt;
    logic            rxd_meta, rxd_s;
    logic [1:0]      sync_ok;
    logic [TW-1:0]   tick;
    logic [2:0]      bit_cnt, last_bit;
    logic [7:0]      data;
    logic [1:0]      wl;
    logic            pen, eps, stick;
    logic            pe, any_one;
    logic            smp, last_tick, par_exp;
    logic            push, do_push, do_pop, full, ovr;
    logic [10:0]     entry;
    logic [10:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     cnt;
    logic            unused_stop;

    // Stop-bit count only matters to the transmitter.
    assign unused_stop = lcr[2];

    assign smp       = baud_o && tick == TW'(SAMPLE_PT);
    assign last_tick = baud_o && tick == TW'(OVERSAMPLE - 1);
    assign last_bit  = {1'b0, wl} + 3'd4;
    assign par_exp   = stick ? ~eps : (eps ? ^data : ~^data);
    assign rx_busy   = !(state == WAIT_IDLE || state == IDLE);

    // Break: every bit of the frame, including the stop bit, sampled low.
    assign push  = state == STOP && smp;
    assign entry = {!any_one && !rxd_s, !rxd_s, pe, (!any_one && !rxd_s) ? 8'h00 : data};

    // sync_ok masks the reset value of the synchroniser until real line data has reached rxd_s.
    always_ff @(posedge clock or negedge PRESETn) begin
        if (!PRESETn) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            sync_ok  <= 2'b00;
            state    <= WAIT_IDLE;
        end else begin
            rxd_meta <= RXD;
            rxd_s    <= rxd_meta;
            sync_ok  <= {sync_ok[0], 1'b1};
            state    <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (baud_o) begin
            case (state)
                WAIT_IDLE: state_nxt = (rxd_s && sync_ok[1]) ? IDLE : WAIT_IDLE;
                IDLE:      state_nxt = rxd_s ? IDLE : START;
                START:     state_nxt = (smp && rxd_s) ? IDLE : (last_tick ? DATA : START);
                DATA:      state_nxt = (last_tick && bit_cnt == last_bit) ? (pen ? PARITY : STOP) : DATA;
                PARITY:    state_nxt = last_tick ? STOP : PARITY;
                STOP:      state_nxt = smp ? (rxd_s ? IDLE : WAIT_IDLE) : STOP;
                default:   state_nxt = WAIT_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge PRESETn) begin
        if (!PRESETn) begin
            tick    <= '0;
            bit_cnt <= '0;
            data    <= '0;
            wl      <= '0;
            pen     <= 1'b0;
            eps     <= 1'b0;
            stick   <= 1'b0;
            pe      <= 1'b0;
            any_one <= 1'b0;
        end else if (baud_o) begin
            tick <= (state == WAIT_IDLE || state == IDLE || last_tick) ? '0 : tick + 1'b1;
            // A confirmed start bit freezes the line format for the whole frame.
            if (state == START && smp && !rxd_s) begin
                wl      <= lcr[1:0];
                pen     <= lcr[3];
                eps     <= lcr[4];
                stick   <= lcr[5];
                data    <= '0;
                bit_cnt <= '0;
                pe      <= 1'b0;
                any_one <= 1'b0;
            end
            if (state == DATA && smp) begin
                data[bit_cnt] <= rxd_s;
                any_one       <= any_one | rxd_s;
            end
            if (state == DATA && last_tick)
                bit_cnt <= bit_cnt + 1'b1;
            if (state == PARITY && smp) begin
                pe      <= rxd_s != par_exp;
                any_one <= any_one | rxd_s;
            end
        end
    end

    assign full    = cnt == (AW + 1)'(FIFO_DEPTH);
    assign do_pop  = rx.rx_pop && cnt != '0;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovr    <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
            ovr <= push && full && !do_pop;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= entry;
    end

    assign rx.rx_fifo_empty = cnt == '0;
    assign rx.rx_fifo_full  = full;
    assign rx.rx_fifo_count = cnt;
    assign rx.rx_data       = cnt == '0 ? 8'h00 : mem[rd_ptr][7:0];
    assign rx.rx_status     = cnt == '0 ? 3'b000 : mem[rd_ptr][10:8];
    assign rx.overrun       = ovr;
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed self-checking bench for uart_rx_core (baud_o every 4 clocks, 64 clocks per bit).
module tb_uart_rx_core;
    logic       clock = 1'b0;
    logic       PRESETn = 1'b0;
    logic       RXD = 1'b1;
    logic [5:0] lcr = 6'b000011;
    logic [1:0] bdiv = 2'd0;
    logic       baud_o;
    logic       rx_busy;
    int         checks = 0;
    int         errors = 0;
    int         ov_cnt = 0;
    int         ov0;

    uart_rx_core_if rx_if();

    uart_rx_core dut (
        .clock   (clock),
        .PRESETn (PRESETn),
        .baud_o  (baud_o),
        .RXD     (RXD),
        .lcr     (lcr),
        .rx_busy (rx_busy),
        .rx      (rx_if)
    );

    always #5 clock = ~clock;
    always @(posedge clock) bdiv <= bdiv + 2'd1;
    assign baud_o = bdiv == 2'd3;
    always @(negedge clock) if (rx_if.overrun) ov_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pop();
        rx_if.rx_pop = 1'b1;
        wait_clk(1);
        rx_if.rx_pop = 1'b0;
    endtask

    // Frame starts right after a baud-tick edge; with pop_at_push the pop lands on the stop-bit sample edge.
    task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen, input bit pbit, input bit pop_at_push);
        @(negedge clock);
        while (!baud_o) @(negedge clock);
        @(posedge clock);
        #1 RXD = 1'b0;
        wait_clk(64);
        for (int i = 0; i < nbits; i++) begin
            RXD = d[i];
            wait_clk(64);
        end
        if (pen) begin
            RXD = pbit;
            wait_clk(64);
        end
        RXD = 1'b1;
        if (pop_at_push) begin
            wait_clk(35);
            rx_if.rx_pop = 1'b1;
            wait_clk(1);
            rx_if.rx_pop = 1'b0;
            wait_clk(28);
        end else begin
            wait_clk(64);
        end
    endtask

    initial begin
        rx_if.rx_pop = 1'b0;
        wait_clk(3);
        check("rst_empty", rx_if.rx_fifo_empty, 1);
        check("rst_full", rx_if.rx_fifo_full, 0);
        check("rst_count", rx_if.rx_fifo_count, 0);
        check("rst_data", rx_if.rx_data, 0);
        check("rst_status", rx_if.rx_status, 0);
        check("rst_overrun", rx_if.overrun, 0);
        check("rst_busy", rx_busy, 0);
        PRESETn = 1'b1;
        wait_clk(64);

        send_frame(8'hA5, 8, 0, 0, 0);
        wait_clk(8);
        check("8n1_count", rx_if.rx_fifo_count, 1);
        check("8n1_data", rx_if.rx_data, 8'hA5);
        check("8n1_status", rx_if.rx_status, 3'b000);
        check("8n1_empty", rx_if.rx_fifo_empty, 0);
        pop();
        check("8n1_pop_empty", rx_if.rx_fifo_empty, 1);
        check("8n1_pop_data", rx_if.rx_data, 0);

        lcr = 6'b011010;
        send_frame(8'h41, 7, 1, 1, 0);
        wait_clk(8);
        check("7e1_bad_data", rx_if.rx_data, 8'h41);
        check("7e1_bad_status", rx_if.rx_status, 3'b001);
        pop();
        send_frame(8'h41, 7, 1, 0, 0);
        wait_clk(8);
        check("7e1_good_data", rx_if.rx_data, 8'h41);
        check("7e1_good_status", rx_if.rx_status, 3'b000);
        pop();
        lcr = 6'b000011;

        RXD = 1'b0;
        wait_clk(20);
        check("glitch_busy", rx_busy, 1);
        RXD = 1'b1;
        wait_clk(100);
        check("glitch_idle", rx_busy, 0);
        check("glitch_empty", rx_if.rx_fifo_empty, 1);

        RXD = 1'b0;
        wait_clk(1280);
        check("brk_count", rx_if.rx_fifo_count, 1);
        check("brk_data", rx_if.rx_data, 0);
        check("brk_status", rx_if.rx_status, 3'b110);
        check("brk_busy", rx_busy, 0);
        wait_clk(200);
        check("brk_no_more", rx_if.rx_fifo_count, 1);
        pop();
        RXD = 1'b1;
        wait_clk(128);
        send_frame(8'h55, 8, 0, 0, 0);
        wait_clk(8);
        check("brk_after_count", rx_if.rx_fifo_count, 1);
        check("brk_after_data", rx_if.rx_data, 8'h55);
        check("brk_after_status", rx_if.rx_status, 0);
        pop();

        ov0 = ov_cnt;
        for (int i = 0; i < 16; i++) send_frame(8'(i), 8, 0, 0, 0);
        wait_clk(8);
        check("fill_count", rx_if.rx_fifo_count, 16);
        check("fill_full", rx_if.rx_fifo_full, 1);
        check("fill_no_ovr", ov_cnt - ov0, 0);
        send_frame(8'h10, 8, 0, 0, 0);
        wait_clk(8);
        check("ovr_pulse", ov_cnt - ov0, 1);
        check("ovr_count", rx_if.rx_fifo_count, 16);
        check("ovr_head", rx_if.rx_data, 8'h00);
        for (int i = 0; i < 16; i++) begin
            check("drain_data", rx_if.rx_data, i);
            pop();
        end
        check("drain_empty", rx_if.rx_fifo_empty, 1);

        for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), 8, 0, 0, 0);
        ov0 = ov_cnt;
        send_frame(8'h30, 8, 0, 0, 1);
        check("pp_count", rx_if.rx_fifo_count, 16);
        check("pp_no_ovr", ov_cnt - ov0, 0);
        for (int i = 0; i < 16; i++) begin
            check("pp_drain", rx_if.rx_data, 8'h21 + i);
            pop();
        end
        check("pp_empty", rx_if.rx_fifo_empty, 1);

        send_frame(8'h11, 8, 0, 0, 0);
        check("pre_rst_count", rx_if.rx_fifo_count, 1);
        @(negedge clock);
        while (!baud_o) @(negedge clock);
        @(posedge clock);
        #1 RXD = 1'b0;
        wait_clk(192);
        RXD = 1'b1;
        wait_clk(32);
        check("mid_busy", rx_busy, 1);
        RXD = 1'b0;
        PRESETn = 1'b0;
        wait_clk(2);
        check("mid_rst_empty", rx_if.rx_fifo_empty, 1);
        check("mid_rst_count", rx_if.rx_fifo_count, 0);
        check("mid_rst_data", rx_if.rx_data, 0);
        check("mid_rst_status", rx_if.rx_status, 0);
        check("mid_rst_busy", rx_busy, 0);
        check("mid_rst_ovr", rx_if.overrun, 0);
        wait_clk(8);
        PRESETn = 1'b1;
        wait_clk(700);
        check("low_rel_empty", rx_if.rx_fifo_empty, 1);
        check("low_rel_busy", rx_busy, 0);
        RXD = 1'b1;
        wait_clk(128);
        send_frame(8'h3C, 8, 0, 0, 0);
        wait_clk(8);
        check("post_rst_count", rx_if.rx_fifo_count, 1);
        check("post_rst_data", rx_if.rx_data, 8'h3C);
        check("post_rst_status", rx_if.rx_status, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Receive half of the APB UART: deserialises the RXD line into characters and queues them in a 16-entry RX FIFO, each entry tagged with per-character error status.
- Uses the baud_o 16x oversampling enable from the baud generator.
- Consumed by the APB register block:
  - RBR read pops the FIFO.
  - LSR is built from the flag and status outputs.
- Counterpart of the existing TX path (tx_fifo_* flags).

Parameters:
- FIFO_DEPTH, 16, RX FIFO entries (power of 2).
- OVERSAMPLE, 16, baud_o ticks per bit.
- SAMPLE_PT, 7, tick index within a bit at which RXD is sampled.

Ports:
- clock  in  1  system clock.
- PRESETn  in  1  asynchronous active-low reset.
- baud_o  in  1  one-clock enable pulse, 16x bit rate.
- RXD  in  1  serial input, idle high, asynchronous to clock.
- lcr  in  6  [1:0] word length 5/6/7/8; [2] stop bits (ignored on receive); [3] parity enable; [4] even parity select; [5] stick parity.
- rx_pop  in  1  pop head entry; ignored when empty.
- rx_data  out  8  head data, first-word-fall-through; 0 when empty.
- rx_status  out  3  head status {bi, fe, pe}; 0 when empty.
- rx_fifo_empty  out  1  FIFO empty.
- rx_fifo_full  out  1  FIFO full.
- rx_fifo_count  out  5  occupancy, 0..16.
- overrun  out  1  one-cycle pulse: character arrived while full.
- rx_busy  out  1  frame in progress (state not WAIT_IDLE/IDLE).

Behaviour:
- Reset (async): FIFO empty, count 0, rx_data/rx_status 0, overrun 0, rx_busy 0, state WAIT_IDLE. 2-flop RXD synchroniser resets to 1.
- All state advances only on cycles with baud_o=1, except FIFO pop.
- Tick counter 0..15 per bit; bit counter per frame.
- State machine:
  - WAIT_IDLE: on a tick with synced RXD=1 -> IDLE. Prevents a false start from a line held low through reset or after break.
  - IDLE: on a tick with synced RXD=0 -> START, tick counter = 0.
  - START: at tick SAMPLE_PT, if RXD=1 (glitch) -> IDLE, no push. Otherwise latch lcr for the whole frame and continue. At tick 15 -> DATA.
  - DATA: sample at SAMPLE_PT, LSB first, 5+lcr[1:0] bits; unused upper bits of rx_data are 0. After the last bit -> PARITY if lcr[3], else STOP.
  - PARITY: sample at SAMPLE_PT.
    - Expected bit: ^data if even (lcr[4]=1); ~^data if odd. With stick (lcr[5]=1): ~lcr[4].
    - pe = sampled != expected.
  - STOP: sample first stop bit at SAMPLE_PT.
    - fe = (bit==0).
    - bi = all data bits, the parity bit if enabled, and the stop bit sampled 0.
    - On bi: data=0x00, fe=1, pe as computed.
    - Push at this same sample point.
    - Next state: WAIT_IDLE if stop bit was 0, else IDLE. No wait for the end of the stop bit, so back-to-back frames are not lost.
- lcr changes mid-frame have no effect until the next START validation.
- Latency: FIFO entry visible (rx_fifo_empty falls) the clock after the stop-bit sample tick.
- FIFO: 16 x 11-bit circular buffer, pointers wrap at FIFO_DEPTH.
  - Pop when empty: no effect.
  - Push when full: entry dropped, overrun=1 for one cycle.
  - Simultaneous push+pop when full: both occur, count stays 16, no overrun.
  - Simultaneous push+pop when empty: push only (pop ignored), count becomes 1.
- Reset mid-frame: partial character discarded, FIFO cleared, state WAIT_IDLE.

Test Plan:
- Frame 8N1, 0xA5, baud_o every 4 clocks -> one entry, rx_data=0xA5, rx_status=000, count=1. rx_pop -> empty.
- 7E1 (lcr=6'b011010), 0x41 with parity bit 1 (wrong) -> rx_data=0x41, pe=1. Same character with parity 0 -> pe=0.
- RXD low for 5 ticks, then high (glitch) -> no entry, rx_busy returns 0, state IDLE.
- RXD held low for 2 frame times, 8N1 -> exactly one entry 0x00 with bi=1, fe=1. No further entry until RXD goes high, then 0x55 is received normally.
- 17 back-to-back 0x00..0x10 with no pops -> count=16, overrun pulse on the 17th, head=0x00. 16 pops return 0x00..0x0F in order. On the 17th character arriving while full, asserting rx_pop in the push cycle -> no overrun, count=16.
- PRESETn asserted during the DATA state of 0x3C -> all outputs 0/empty. RXD held low across reset release -> no entry until RXD goes high, then the next frame decodes correctly.
